// File: rtl/fetch_if.sv
// Fetch controller bus: ROM read port, decode-side valid/ready delivery,
// redirect and halt control, status flags.
//
// Handshake: decode takes the head word on a rising edge where instr_valid
// and instr_ready are both high. instr_valid never depends on instr_ready,
// and the head word stays stable until it is taken or a redirect flushes it.
interface fetch_if #(
  parameter int N = 32
);
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_rd;
  logic [N-1:0] instr;
  logic [N-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         halt_req;
  logic         halted;
  logic         fault;

  // Fetch controller side
  modport master (
    output mem_addr, instr, instr_pc, instr_valid, halted, fault,
    input  mem_rd, instr_ready, redirect_valid, redirect_pc, halt_req
  );

  // ROM / decode / branch-unit side
  modport slave (
    input  mem_addr, instr, instr_pc, instr_valid, halted, fault,
    output mem_rd, instr_ready, redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads a same-cycle ROM, queues
// words in a 2-entry buffer and hands them to decode over valid/ready.
// Redirects flush the buffer; misaligned redirect targets set a sticky fault
// and halt fetching.
// Optional macro FETCH_BOUNDS_CHECK_EN: halt with fault when the PC runs past
// the last ROM word (DEPTH words).
module fetch_ctrl #(
  parameter int          N        = 32,
  parameter int          DEPTH    = 39,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [N-1:0] LIMIT = N'(DEPTH * 4);
  localparam logic [N-1:0] STEP  = N'(4);

  state_t       state_q, state_d;
  logic [N-1:0] pc_q;
  logic [1:0]   count_q;
  logic         fault_q;
  logic         fault_set;
  logic [N-1:0] word0_q, word1_q;
  logic [N-1:0] wpc0_q, wpc1_q;
  logic         push, pop;
  logic         aligned;
  logic         bounds_hit;

  // Head slot is always buf[0]; it is only overwritten by a new word or a
  // shift, so instr/instr_pc keep their last value while the buffer is empty.
  assign bus.mem_addr    = pc_q;
  assign bus.instr       = word0_q;
  assign bus.instr_pc    = wpc0_q;
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.halted      = (state_q == HALT);
  assign bus.fault       = fault_q;

  assign aligned = (bus.redirect_pc[1:0] == 2'b00);

`ifdef FETCH_BOUNDS_CHECK_EN
  assign bounds_hit = (pc_q >= LIMIT);
`else
  // Range check disabled: the comparison is kept but masked to a constant.
  assign bounds_hit = 1'b0 & (pc_q >= LIMIT);
`endif

  // Next state, push/pop decisions and fault detection
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    fault_set = 1'b0;
    pop       = (count_q != 2'd0) && bus.instr_ready;
    if (bus.redirect_valid) begin
      if (!aligned) begin
        fault_set = 1'b1;
        state_d   = HALT;
      end else begin
        state_d = bus.halt_req ? HALT : RUN;
      end
    end else if (state_q == RUN) begin
      if (bounds_hit) begin
        fault_set = 1'b1;
        state_d   = HALT;
      end else begin
        push = (count_q != 2'd2) || pop;
        if (bus.halt_req) state_d = HALT;
      end
    end
  end

  // State register and sticky fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fault_set) fault_q <= 1'b1;
    end
  end

  // PC, buffer occupancy and buffer contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= N'(RESET_PC);
      count_q <= 2'd0;
      word0_q <= '0;
      word1_q <= '0;
      wpc0_q  <= '0;
      wpc1_q  <= '0;
    end else if (bus.redirect_valid) begin
      count_q <= 2'd0;
      if (aligned) pc_q <= bus.redirect_pc;
    end else begin
      if (push) pc_q <= pc_q + STEP;
      case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            word0_q <= word1_q;
            wpc0_q  <= wpc1_q;
            word1_q <= bus.mem_rd;
            wpc1_q  <= pc_q;
          end else begin
            word0_q <= bus.mem_rd;
            wpc0_q  <= pc_q;
          end
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            word0_q <= word1_q;
            wpc0_q  <= wpc1_q;
          end
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            word0_q <= bus.mem_rd;
            wpc0_q  <= pc_q;
          end else begin
            word1_q <= bus.mem_rd;
            wpc1_q  <= pc_q;
          end
          count_q <= count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer sitting between the core's decode stage and the combinational instruction ROM (word-indexed by byte address bits [N-1:2], data returned same cycle).
- Owns the PC, issues sequential fetch addresses and captures returned words into a 2-entry fetch buffer.
- Delivers words to decode over a valid/ready handshake.
- Handles branch redirects, halt requests and misaligned-target faults.

Parameters:
N, 32, address/data width in bits
DEPTH, 39, number of 32-bit words in the instruction ROM
RESET_PC, 0, byte address fetched first after reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
mem_addr  output  N  byte address driven to ROM read address
mem_rd  input  N  ROM read data, valid in the same cycle as mem_addr
instr  output  N  instruction word at buffer head
instr_pc  output  N  byte address of instr
instr_valid  output  1  buffer head holds a valid word
instr_ready  input  1  decode accepts head this cycle
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  N  byte target of redirect
halt_req  input  1  stop fetching after current cycle
halted  output  1  controller is in HALT state
fault  output  1  sticky error flag (misaligned target or bounds violation)

Behaviour:
- Reset (rst_n low, async): pc_q=RESET_PC, buffer empty (count=0), state=RUN, instr_valid=0, instr=0, instr_pc=0, halted=0, fault=0.
- mem_addr = pc_q combinationally at all times.
- States:
  - RUN: fetches.
  - HALT: no fetch, buffer drains normally.
- Transitions:
  - RUN->HALT on halt_req, misaligned redirect or (with macro) bounds fault.
  - HALT->RUN only on aligned redirect_valid.
- Push in RUN: when (count<2) or (count==2 and pop this cycle):
  - enqueue {pc_q, mem_rd};
  - pc_q <= pc_q+4, mod 2^N wrap.
- Pop: instr_valid && instr_ready removes head. Simultaneous push+pop keeps count unchanged, ordering preserved.
- Full (count==2) and no pop: no push, pc_q holds.
- Empty: instr_valid=0. instr and instr_pc hold their last value (0 after reset).
- Latency: first word after reset appears with instr_valid=1 in the first cycle after reset release plus one edge (push at edge 1, visible after it).
- Redirect has highest priority:
  - flush buffer (count=0);
  - no push that cycle; any pop that cycle is discarded;
  - pc_q <= redirect_pc.
  - Target word is visible on instr one cycle later, i.e. the redirect costs 1 bubble cycle.
- redirect_pc[1:0]!=0: flush, fault<=1, state HALT, pc_q unchanged.
- halt_req same cycle as aligned redirect: redirect wins for pc/flush, state goes HALT (halt wins for state).
- halt_req in RUN: the push in that cycle still occurs; HALT from next cycle.
- fault is sticky until reset. Redirect out of HALT does not clear it.
- halted = (state==HALT), registered.

Optional Feature:
- Macro FETCH_BOUNDS_CHECK_EN.
- Defined: in RUN, if pc_q >= DEPTH*4, suppress push, set fault<=1 and enter HALT. A redirect to an out-of-range target behaves the same on the following cycle.
- Undefined: no range check; pc_q wraps at 2^N and ROM addressing is the caller's concern.

Test Plan:
- Reset release, instr_ready=1, mem_rd=ROM model -> instr_pc sequence 0x00,0x04,0x08… one per cycle, instr_valid=1 from cycle 2 onward, no gaps.
- instr_ready=0 for 5 cycles from reset -> count saturates at 2 (pcs 0x00,0x04); mem_addr holds 0x08; on ready=1 words 0x00,0x04,0x08 delivered in order, no duplicates.
- redirect_valid with redirect_pc=0x40 while buffer full -> next cycle instr_valid=0; following cycle instr_pc=0x40; old 0x08 never delivered.
- redirect_pc=0x42 -> fault=1, halted=1 next cycle, mem_addr unchanged; later redirect 0x10 -> halted=0, fetch resumes at 0x10, fault stays 1.
- halt_req for 1 cycle at pc_q=0x0C, ready=0 -> buffer drains 2 entries when ready=1, then instr_valid=0, mem_addr stays 0x10.
- With FETCH_BOUNDS_CHECK_EN, DEPTH=39: run sequentially to pc 0x98 -> word at 0x98 delivered, fetch of 0x9C suppressed, fault=1, halted=1; without macro pc continues to 0x9C.
